// File: rtl/sreg_rr_arbiter_if.sv
// Requester-side bus of the shared signed register arbiter.
// The lock vector exists only when SREG_ARB_LOCK_EN is defined.
interface sreg_rr_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
);
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]             req;
    logic [NREQ*DATAWIDTH-1:0]   d_flat;
    logic [NREQ-1:0]             gnt;
    logic signed [DATAWIDTH-1:0] q;
    logic                        q_valid;
    logic [SRCW-1:0]             q_src;
    logic                        busy;
`ifdef SREG_ARB_LOCK_EN
    logic [NREQ-1:0]             lock;

    modport master (output req, d_flat, lock, input gnt, q, q_valid, q_src, busy);
    modport slave  (input req, d_flat, lock, output gnt, q, q_valid, q_src, busy);
`else
    modport master (output req, d_flat, input gnt, q, q_valid, q_src, busy);
    modport slave  (input req, d_flat, output gnt, q, q_valid, q_src, busy);
`endif
endinterface

// File: rtl/sreg_rr_arbiter.sv
// Round-robin arbiter loading one requester's signed data into a shared register.
// Optional lock/burst mode under macro SREG_ARB_LOCK_EN.
module sreg_rr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    sreg_rr_arbiter_if.slave bus
);
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [SRCW-1:0]             ptr_q, ptr_d;
    logic [SRCW-1:0]             win_q, win_d;
    logic [SRCW-1:0]             q_src_q, q_src_d;
    logic [NREQ-1:0]             gnt_q, gnt_d;
    logic signed [DATAWIDTH-1:0] q_q, q_d;
    logic                        q_valid_q, q_valid_d;
    logic                        rr_found;
    logic [SRCW-1:0]             rr_win;
    logic [SRCW-1:0]             cand;
    logic                        hold;
    logic signed [DATAWIDTH-1:0] d_arr [NREQ];

    function automatic logic [SRCW-1:0] wrap_add(input logic [SRCW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[SRCW-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign d_arr[gi] = bus.d_flat[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

`ifdef SREG_ARB_LOCK_EN
    // A locked winner keeps the register and writes every cycle.
    assign hold = bus.req[win_q] & bus.lock[win_q];
`else
    assign hold = 1'b0;
`endif

    // First requester at or after ptr, wrapping at NREQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(ptr_q, k);
            if (!rr_found && bus.req[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_src_q   <= q_src_d;
            q_valid_q <= q_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rr_found) state_d = WRITE;
            WRITE:   if (!hold)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_src_d   = q_src_q;
        q_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (rr_found) begin
                    win_d = rr_win;
                    gnt_d = NREQ'(1) << rr_win;
                end
            end
            WRITE: begin
                q_d       = d_arr[win_q];
                q_src_d   = win_q;
                q_valid_d = 1'b1;
                if (!hold) begin
                    gnt_d = '0;
                    ptr_d = wrap_add(win_q, 1);
                end
            end
            default: gnt_d = '0;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.q_src   = q_src_q;
    assign bus.busy    = (state_q == WRITE);
endmodule

// File: tb/tb_sreg_rr_arbiter.sv
// Bench for sreg_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant/write phases, round-robin pointer).
module tb_sreg_rr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    sreg_rr_arbiter_if #(.DATAWIDTH(DW), .NREQ(NR)) bus ();
    sreg_rr_arbiter #(.DATAWIDTH(DW), .NREQ(NR)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: phase 0 = waiting for requests, phase 1 = a grant is out.
    int                 m_phase, m_w, m_ptr, m_src;
    logic signed [DW-1:0] m_q;
    bit                 m_qv;
    logic [NR-1:0]      m_gnt;

    function automatic void model_step();
        bit found;
        bit keep;
        if (Rst) begin
            m_phase = 0; m_w = 0; m_ptr = 0; m_src = 0; m_q = '0; m_qv = 0; m_gnt = '0;
        end else if (m_phase == 0) begin
            m_qv = 0;
            m_gnt = '0;
            found = 0;
            for (int k = 0; k < NR; k++) begin
                if (!found && bus.req[(m_ptr + k) % NR]) begin
                    found = 1;
                    m_w = (m_ptr + k) % NR;
                end
            end
            if (found) begin
                m_gnt = NR'(1) << m_w;
                m_phase = 1;
            end
        end else begin
            m_q   = bus.d_flat[m_w*DW +: DW];
            m_src = m_w;
            m_qv  = 1;
            keep  = 0;
`ifdef SREG_ARB_LOCK_EN
            keep = bus.req[m_w] && bus.lock[m_w];
`endif
            if (!keep) begin
                m_gnt   = '0;
                m_phase = 0;
                m_ptr   = (m_w + 1) % NR;
            end
        end
    endfunction

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_d(input int idx, input logic [DW-1:0] v);
        bus.d_flat[idx*DW +: DW] = v;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.req = 4'hF;
        cycle();
        cycle();
        checks++; if (bus.q !== 8'h00)   begin errors++; $display("FAIL reset_q got %h want 00", bus.q); end
        checks++; if (bus.gnt !== 4'h0)  begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_qv got %b want 0", bus.q_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        Rst = 1'b0;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", bus.gnt); end
        bus.req = 4'h0;
        cycle();
        cycle();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        set_d(2, 8'hFB);
        cycle();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", bus.gnt); end
        checks++; if (bus.busy !== 1'b1)   begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
        bus.req = 4'b0000;
        cycle();
        checks++; if (bus.q !== 8'hFB)      begin errors++; $display("FAIL single_q got %h want fb", bus.q); end
        checks++; if (bus.q_src !== 2'd2)   begin errors++; $display("FAIL single_src got %0d want 2", bus.q_src); end
        checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL single_qv got %b want 1", bus.q_valid); end
        checks++; if (bus.gnt !== 4'b0000)  begin errors++; $display("FAIL single_gnt_drop got %b want 0000", bus.gnt); end
        cycle();
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL single_qv_pulse got %b want 0", bus.q_valid); end
        checks++; if (bus.q !== 8'hFB)      begin errors++; $display("FAIL single_q_hold got %h want fb", bus.q); end
        $display("test_single done");
    endtask

    task automatic test_rotation();
        Rst = 1'b1;
        bus.req = 4'h0;
        cycle();
        Rst = 1'b0;
        for (int i = 0; i < NR; i++) set_d(i, DW'(i + 1));
        bus.req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (bus.gnt !== (4'b0001 << (n % NR))) begin
                errors++; $display("FAIL rot_gnt n=%0d got %b want %b", n, bus.gnt, 4'b0001 << (n % NR));
            end
            cycle();
            checks++;
            if (bus.q !== DW'(n % NR + 1) || bus.q_valid !== 1'b1) begin
                errors++; $display("FAIL rot_q n=%0d got %0d/%b want %0d/1", n, bus.q, bus.q_valid, n % NR + 1);
            end
        end
        bus.req = 4'h0;
        cycle();
        $display("test_rotation done");
    endtask

    task automatic test_wrap();
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        bus.req = 4'b1010;
        cycle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wrap_g1 got %b want 0010", bus.gnt); end
        bus.req = 4'b1000;
        cycle();
        cycle();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got %b want 1000", bus.gnt); end
        bus.req = 4'b1010;
        cycle();
        checks++; if (bus.q_src !== 2'd3) begin errors++; $display("FAIL wrap_src got %0d want 3", bus.q_src); end
        cycle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wrap_g1_again got %b want 0010", bus.gnt); end
        bus.req = 4'h0;
        cycle();
        cycle();
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_write();
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        bus.req = 4'b0001;
        set_d(0, 8'd7);
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rmw_gnt got %b want 0001", bus.gnt); end
        Rst = 1'b1;
        bus.req = 4'h0;
        cycle();
        checks++; if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
            errors++; $display("FAIL rmw_q got %h/%b want 00/0", bus.q, bus.q_valid);
        end
        Rst = 1'b0;
        cycle();
        checks++; if (bus.q_valid !== 1'b0 || bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
            errors++; $display("FAIL rmw_after got qv=%b gnt=%b busy=%b q=%h want 0/0000/0/00",
                               bus.q_valid, bus.gnt, bus.busy, bus.q);
        end
        $display("test_reset_mid_write done");
    endtask

`ifdef SREG_ARB_LOCK_EN
    task automatic test_lock();
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        set_d(0, 8'd10);
        set_d(1, 8'd20);
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt got %b want 0001", bus.gnt); end
        for (int n = 0; n < 3; n++) begin
            if (n == 2) bus.lock = 4'b0000;
            cycle();
            checks++;
            if (bus.q !== 8'd10 || bus.q_valid !== 1'b1 || bus.gnt !== ((n < 2) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL lock_write n=%0d got q=%0d qv=%b gnt=%b", n, bus.q, bus.q_valid, bus.gnt);
            end
        end
        cycle();
        checks++; if (bus.gnt !== 4'b0010 || bus.q_valid !== 1'b0) begin
            errors++; $display("FAIL lock_release got gnt=%b qv=%b want 0010/0", bus.gnt, bus.q_valid);
        end
        bus.req = 4'h0;
        cycle();
        cycle();
        $display("test_lock done");
    endtask
`endif

    task automatic test_random();
        Rst = 1'b1;
        bus.req = 4'h0;
        cycle();
        Rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            Rst = ($urandom_range(0, 39) == 0);
            bus.req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            bus.d_flat = 32'($urandom);
`ifdef SREG_ARB_LOCK_EN
            bus.lock = 4'($urandom);
`endif
            cycle();
            checks++;
            if (bus.gnt !== m_gnt || bus.q !== m_q || bus.q_valid !== m_qv ||
                bus.q_src !== 2'(m_src) || bus.busy !== (m_phase == 1)) begin
                errors++;
                $display("FAIL rand n=%0d got gnt=%b q=%h qv=%b src=%0d busy=%b want gnt=%b q=%h qv=%b src=%0d busy=%b",
                         n, bus.gnt, bus.q, bus.q_valid, bus.q_src, bus.busy,
                         m_gnt, m_q, m_qv, m_src, m_phase == 1);
            end
        end
        Rst = 1'b0;
        bus.req = 4'h0;
        $display("test_random done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst = 1'b1;
        bus.req = '0;
        bus.d_flat = '0;
`ifdef SREG_ARB_LOCK_EN
        bus.lock = '0;
`endif
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_reset_mid_write();
`ifdef SREG_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
